// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants shared by the raster counter and the sync decoder.
package vga_timing_pkg;

  localparam int unsigned HD = 640;
  localparam int unsigned HF = 16;
  localparam int unsigned HB = 48;
  localparam int unsigned HR = 96;
  localparam int unsigned VD = 480;
  localparam int unsigned VF = 10;
  localparam int unsigned VB = 33;
  localparam int unsigned VR = 2;

  localparam int unsigned H_TOTAL = HD + HF + HR + HB;
  localparam int unsigned V_TOTAL = VD + VF + VR + VB;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned CNT_MAX = 1024;
  localparam int unsigned DIV_MAX = 16;
  localparam int unsigned FRAME_W = 8;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_mod_counter.sv
// Modulo-N counter with count enable, same-cycle wrap strobe and synchronous active-low reset.
module vga_mod_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned N = 2,
  parameter int unsigned W = cnt_w(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  logic [W-1:0] r_count;

  assign o_wrap  = i_inc && (r_count == W'(N - 1));
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (o_wrap) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_counter.sv
// Free-running VGA raster position generator: pixel divider, column and line counters.
// Optional 8-bit frame counter port enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned DIV     = 4,
  parameter int unsigned H_TOTAL = vga_timing_pkg::H_TOTAL,
  parameter int unsigned V_TOTAL = vga_timing_pkg::V_TOTAL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             pix_tick,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             line_end,
  output logic             frame_end
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [FRAME_W-1:0] frame_cnt
`endif
);

  localparam int unsigned DIV_W = cnt_w(DIV);
  localparam int unsigned H_W   = cnt_w(H_TOTAL);
  localparam int unsigned V_W   = cnt_w(V_TOTAL);

  if (DIV < 1 || DIV > DIV_MAX) begin : g_bad_div
    $error("vga_timing_counter: DIV must be in 1..16");
  end
  if (H_TOTAL < 1 || H_TOTAL > CNT_MAX) begin : g_bad_h
    $error("vga_timing_counter: H_TOTAL must be in 1..1024");
  end
  if (V_TOTAL < 1 || V_TOTAL > CNT_MAX) begin : g_bad_v
    $error("vga_timing_counter: V_TOTAL must be in 1..1024");
  end

  // Divider phase is internal; only its wrap (the pixel tick) leaves the block.
  logic [DIV_W-1:0] w_unused_div_cnt;
  logic [H_W-1:0]   w_h_count;
  logic [V_W-1:0]   w_v_count;
  logic             w_pix_tick;
  logic             w_line_end;
  logic             w_frame_end;

  vga_mod_counter #(.N(DIV), .W(DIV_W)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (en),
    .o_count (w_unused_div_cnt),
    .o_wrap  (w_pix_tick)
  );

  vga_mod_counter #(.N(H_TOTAL), .W(H_W)) u_h (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_pix_tick),
    .o_count (w_h_count),
    .o_wrap  (w_line_end)
  );

  vga_mod_counter #(.N(V_TOTAL), .W(V_W)) u_v (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_line_end),
    .o_count (w_v_count),
    .o_wrap  (w_frame_end)
  );

  assign pix_tick  = w_pix_tick;
  assign line_end  = w_line_end;
  assign frame_end = w_frame_end;
  assign h_count   = CNT_W'(w_h_count);
  assign v_count   = CNT_W'(w_v_count);

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_W-1:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_frame_end) begin
      r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_counter.sv
// Bench for vga_timing_counter: two instances checked against an enabled-cycle arithmetic model.
module tb_vga_timing_counter;

  localparam int unsigned A_DIV = 4;
  localparam int unsigned A_H   = 800;
  localparam int unsigned A_V   = 5;
  localparam int unsigned B_DIV = 1;
  localparam int unsigned B_H   = 8;
  localparam int unsigned B_V   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  always #5 clk = ~clk;

  logic       a_tick, a_le, a_fe, b_tick, b_le, b_fe;
  logic [9:0] a_h, a_v, b_h, b_v;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] a_fc, b_fc;
`endif

  vga_timing_counter #(.DIV(A_DIV), .H_TOTAL(A_H), .V_TOTAL(A_V)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .pix_tick  (a_tick),
    .h_count   (a_h),
    .v_count   (a_v),
    .line_end  (a_le),
    .frame_end (a_fe)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt (a_fc)
`endif
  );

  vga_timing_counter #(.DIV(B_DIV), .H_TOTAL(B_H), .V_TOTAL(B_V)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .pix_tick  (b_tick),
    .h_count   (b_h),
    .v_count   (b_v),
    .line_end  (b_le),
    .frame_end (b_fe)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt (b_fc)
`endif
  );

  int     n_vec = 0;
  int     n_err = 0;
  bit     chk_on = 1'b0;
  // Number of enabled clocks since the last reset: every output follows from it.
  longint m_t = 0;

  always @(posedge clk) begin
    if (!rst_n)  m_t <= 0;
    else if (en) m_t <= m_t + 1;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input string tag, input longint dv, input longint ht, input longint vt,
                          input logic tick, input logic le, input logic fe,
                          input logic [9:0] h, input logic [9:0] v);
    longint pix;
    longint eh;
    longint ev;
    logic   et;
    logic   ele;
    logic   efe;
    pix = m_t / dv;
    eh  = pix % ht;
    ev  = (pix / ht) % vt;
    et  = en && ((m_t % dv) == dv - 1);
    ele = et && (eh == ht - 1);
    efe = ele && (ev == vt - 1);
    chk({tag, ".h_count"},   longint'(h),    eh);
    chk({tag, ".v_count"},   longint'(v),    ev);
    chk({tag, ".pix_tick"},  longint'(tick), longint'(et));
    chk({tag, ".line_end"},  longint'(le),   longint'(ele));
    chk({tag, ".frame_end"}, longint'(fe),   longint'(efe));
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp_inst("a", longint'(A_DIV), longint'(A_H), longint'(A_V), a_tick, a_le, a_fe, a_h, a_v);
      cmp_inst("b", longint'(B_DIV), longint'(B_H), longint'(B_V), b_tick, b_le, b_fe, b_h, b_v);
`ifdef VGA_FRAME_CNT_EN
      chk("a.frame_cnt", longint'(a_fc), (m_t / longint'(A_DIV * A_H * A_V)) % 256);
      chk("b.frame_cnt", longint'(b_fc), (m_t / longint'(B_DIV * B_H * B_V)) % 256);
`endif
    end
  end

  task automatic edge_set(input logic e, input logic r);
    @(posedge clk);
    #2;
    en    = e;
    rst_n = r;
  endtask

  // Called right after reset release with en=1: pins the first-pixel latency.
  task automatic startup_checks();
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      chk("start.pix_tick",  longint'(a_tick), (c == 3) ? 1 : 0);
      chk("start.h_count",   longint'(a_h),    (c == 4) ? 1 : 0);
      chk("start.v_count",   longint'(a_v),    0);
      chk("start.line_end",  longint'(a_le),   0);
      chk("start.frame_end", longint'(a_fe),   0);
    end
  endtask

  initial begin
    longint first_le = -1;
    longint fe0 = -1;
    longint fe1 = -1;
    longint h_wrap = -1;
    longint v_wrap = -1;
    longint h_fe = -1;
    longint v_fe = -1;
    longint h_after = -1;
    longint v_after = -1;
    bit     hit = 1'b0;

    edge_set(1'b1, 1'b0);
    edge_set(1'b1, 1'b1);
    chk_on = 1'b1;
    startup_checks();

    // Continuous run: first line_end, line wrap, frame_end position and spacing.
    for (int c = 5; c < 40000 && fe1 < 0; c++) begin
      @(negedge clk);
      if (a_le && first_le < 0) first_le = c;
      if (c == 3200) begin
        h_wrap = longint'(a_h);
        v_wrap = longint'(a_v);
      end
      if (fe0 >= 0 && c == fe0 + 1) begin
        h_after = longint'(a_h);
        v_after = longint'(a_v);
      end
      if (a_fe) begin
        if (fe0 < 0) begin
          fe0  = c;
          h_fe = longint'(a_h);
          v_fe = longint'(a_v);
        end else begin
          fe1 = c;
        end
      end
    end
    chk("line_end.cycle",    first_le, 3199);
    chk("line_wrap.h",       h_wrap,   0);
    chk("line_wrap.v",       v_wrap,   1);
    chk("frame_end.cycle",   fe0,      15999);
    chk("frame_end.h",       h_fe,     799);
    chk("frame_end.v",       v_fe,     4);
    chk("frame_wrap.h",      h_after,  0);
    chk("frame_wrap.v",      v_after,  0);
    chk("frame_end.spacing", fe1 - fe0, 16000);

    // Mid-line freeze for 37 clocks, then resume.
    edge_set(1'b0, 1'b1);
    repeat (36) @(posedge clk);
    edge_set(1'b1, 1'b1);
    repeat (50) @(posedge clk);

    // Random enable with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      edge_set(($urandom_range(0, 3) != 0), ($urandom_range(0, 999) != 0));
    end
    edge_set(1'b1, 1'b1);

    // Reset landing mid-frame at h=400, v=3.
    for (int c = 0; c < 20000 && !hit; c++) begin
      @(negedge clk);
      if (a_h == 10'd400 && a_v == 10'd3) hit = 1'b1;
    end
    chk("reach_h400_v3", longint'(hit), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    startup_checks();

    for (int i = 0; i < 500; i++) begin
      edge_set(($urandom_range(0, 1) != 0), 1'b1);
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
